core_dispatch_scoreboard: RTL
=============================

Name: core_dispatch_scoreboard

Overview:
- ISSUE_W-wide in-order dispatch gate between decode and the execution units.
- Each cycle it accepts the longest issuable prefix of the decoded bundle.
- Hazard checks:
  - intra-bundle RAW/WAW;
  - structural limits (one mul, one ldst, branch closes the group);
  - RAW/WAW against a per-register countdown scoreboard of in-flight writes with unit-specific latencies.
- The front-end shifts its bundle by issue_count.

Parameters:
- ISSUE_W, 2, bundle width in slots (1..4)
- NREGS, 16, architectural register count
- ALU_LAT, 1, cycles until an ALU result is readable
- MUL_LAT, 3, cycles until a mul result is readable
- LDST_LAT, 2, cycles until a load result is readable

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- bundle_valid  in  1  dec[] holds a valid bundle
- dec  in  insn_decode[ISSUE_W]  decoded slots; slot 0 is oldest
- be_stall  in  1  backend stall: freeze scoreboard, issue nothing
- flush  in  1  discard the current bundle this cycle
- issue_mask  out  ISSUE_W  slots issued this cycle (always a prefix)
- issue_count  out  $clog2(ISSUE_W+1)  popcount of issue_mask
- busy  out  NREGS  reg has pending write (counter != 0), registered

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values:
  - all counters cnt[r] = 0;
  - busy = 0;
  - issue_mask and issue_count are combinational; they are 0 while rst_n is low.
- Latency class of a slot:
  - mul if ctrl.mul;
  - ldst if ctrl.ldst;
  - otherwise ALU.
  - lat = MUL_LAT / LDST_LAT / ALU_LAT.
- Counter width: $clog2(max latency + 1).
- Slot k is issuable iff bundle_valid && !flush && !be_stall && every slot j<k issued, and one of:
  - (a) !ctrl.execute: always issuable, never blocks, never writes the scoreboard;
  - (b) it passes every check below.
- Checks for slot k:
  - Scoreboard RAW: a used source (uses_ra→ra, uses_rb→rb) is readable iff cnt[src] == 0 (bypass variant below).
  - Scoreboard WAW: if writeback, require cnt[rd] <= lat(k). This keeps writebacks in order.
  - Intra-bundle RAW: no issued earlier executing slot j with data.writeback and rd == a used source of k.
  - Intra-bundle WAW: no issued earlier executing writeback slot j with rd(j) == rd(k).
  - Structural: at most one ctrl.mul and at most one ctrl.ldst among executing issued slots. No slot may issue after an executing ctrl.branch slot in the same cycle.
- Scoreboard update at posedge:
  - If be_stall: all cnt hold.
  - Otherwise each nonzero cnt decrements by 1.
  - Then, for each issued executing writeback slot, cnt[rd] <= lat. This new load overrides the decrement of the same reg.
  - Intra-bundle WAW rules guarantee at most one load per reg per cycle.
- flush does not clear the scoreboard; in-flight writes still retire. A flush with be_stall still issues nothing.
- busy[r] is the registered (cnt[r] != 0) after update.
- Reset asserted mid-operation clears all counters immediately; any pending writes are forgotten.
- bundle_valid low gives issue_mask = 0; counters keep draining.

Optional Feature:
- Macro: CORE_DISPATCH_BYPASS_EN.
- Defined: scoreboard RAW also passes when cnt[src] == 1 (forwarding network supplies the value). MUL and LDST sources still need cnt <= 1.
- Undefined: requires cnt[src] == 0; no forwarding assumed.
- Intra-bundle RAW is blocked in both builds.

Decomposition:
- Shared package (core/uarch.sv):
  - insn_decode, reused as is;
  - latency-class enum {LAT_ALU, LAT_MUL, LAT_LDST};
  - default latency constants.
- Natural sub-module: core_dispatch_slot_check, one per slot.
  - Pure combinational: slot k decode, cnt lookups, and an accumulated "earlier issued" summary (dest mask, mul_used, ldst_used, branch_seen).
  - Outputs: ok plus updated summary.
  - Top module chains the instances and owns the counter array.

Test Plan:
- Reset then bundle {add r1←r2,r3; add r4←r5,r6}, bundle_valid=1 → issue_mask=2'b11, count=2; next cycle busy[1]=busy[4]=1; the cycle after, busy=0.
- Slot0 mul r2←r1,r1; slot1 add r3←r2,r0 → mask=2'b01. Next three cycles slot1 add blocked (no bypass) and busy[2]=1. With BYPASS_EN it issues one cycle earlier (cnt[2]==1).
- Two ldst in one bundle → mask=2'b01. Branch in slot0 with a valid slot1 → mask=2'b01.
- Slot0 !execute with rd=r1 writeback; slot1 reads r1 → mask=2'b11, busy[1] stays 0.
- Mul r5 in flight (cnt=3); ALU write to r5 → blocked until cnt<=1, then issues. Busy never drops while a pending write remains.
- be_stall=1 for 2 cycles with cnt[7]=2 → cnt held, mask=0. flush=1 → mask=0, cnt still decrements. rst_n pulse mid-flight → busy=0 immediately.

Source files
------------

// File: rtl/core_dispatch_scoreboard_pkg.sv
// Shared decode types, latency classes and helpers for the dispatch scoreboard.
// Optional build macro CORE_DISPATCH_BYPASS_EN is consumed by the slot checker.
package core_dispatch_scoreboard_pkg;

  localparam int REG_W        = 4;
  localparam int REG_SPACE    = 16;
  localparam int DEF_ALU_LAT  = 1;
  localparam int DEF_MUL_LAT  = 3;
  localparam int DEF_LDST_LAT = 2;

  typedef enum logic [1:0] {
    LAT_ALU  = 2'd0,
    LAT_MUL  = 2'd1,
    LAT_LDST = 2'd2
  } lat_class_e;

  typedef struct packed {
    logic execute;
    logic mul;
    logic ldst;
    logic branch;
  } insn_ctrl_t;

  typedef struct packed {
    logic writeback;
  } insn_data_t;

  typedef struct packed {
    insn_ctrl_t       ctrl;
    insn_data_t       data;
    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] ra;
    logic [REG_W-1:0] rb;
    logic             uses_ra;
    logic             uses_rb;
  } insn_decode;

  // What the already-issued older slots of this cycle have claimed.
  typedef struct packed {
    logic                 prev_ok;
    logic [REG_SPACE-1:0] dest_mask;
    logic                 mul_used;
    logic                 ldst_used;
    logic                 branch_seen;
  } issue_summary_t;

  function automatic lat_class_e lat_class(input insn_ctrl_t c);
    lat_class_e cls;
    if (c.mul) begin
      cls = LAT_MUL;
    end else if (c.ldst) begin
      cls = LAT_LDST;
    end else begin
      cls = LAT_ALU;
    end
    return cls;
  endfunction

  function automatic int lat_of(input insn_ctrl_t c, input int alu, input int mul, input int ldst);
    int lat;
    case (lat_class(c))
      LAT_MUL:  lat = mul;
      LAT_LDST: lat = ldst;
      default:  lat = alu;
    endcase
    return lat;
  endfunction

  function automatic int cnt_width(input int alu, input int mul, input int ldst);
    int mx;
    mx = (alu > mul) ? alu : mul;
    mx = (mx > ldst) ? mx : ldst;
    return $clog2(mx + 1);
  endfunction

endpackage

// File: rtl/core_dispatch_scoreboard_if.sv
// Decode-to-dispatch handshake: bundle in, issue result and busy map out.
interface core_dispatch_scoreboard_if
  import core_dispatch_scoreboard_pkg::*;
#(
  parameter int ISSUE_W = 2,
  parameter int NREGS   = 16
) ();

  logic                           bundle_valid;
  insn_decode                     dec [ISSUE_W];
  logic                           be_stall;
  logic                           flush;
  logic [ISSUE_W-1:0]             issue_mask;
  logic [$clog2(ISSUE_W+1)-1:0]   issue_count;
  logic [NREGS-1:0]               busy;

  modport master (
    output bundle_valid, dec, be_stall, flush,
    input  issue_mask, issue_count, busy
  );

  modport slave (
    input  bundle_valid, dec, be_stall, flush,
    output issue_mask, issue_count, busy
  );

endinterface

// File: rtl/core_dispatch_slot_check.sv
// Combinational issue check for one bundle slot; chains an "older slots" summary.
// CORE_DISPATCH_BYPASS_EN lets a source with one cycle left be read via forwarding.
module core_dispatch_slot_check
  import core_dispatch_scoreboard_pkg::*;
#(
  parameter int NREGS    = 16,
  parameter int ALU_LAT  = DEF_ALU_LAT,
  parameter int MUL_LAT  = DEF_MUL_LAT,
  parameter int LDST_LAT = DEF_LDST_LAT,
  parameter int CNT_W    = cnt_width(ALU_LAT, MUL_LAT, LDST_LAT)
) (
  input  insn_decode                      d,
  input  logic [NREGS-1:0][CNT_W-1:0]     cnt,
  input  issue_summary_t                  sum_in,
  output logic                            ok,
  output issue_summary_t                  sum_out
);

  logic [CNT_W-1:0]     lat_s;
  logic                 raw_sb_s;
  logic                 waw_sb_s;
  logic                 raw_ib_s;
  logic                 waw_ib_s;
  logic                 struct_s;
  logic                 commit_s;
  logic [REG_SPACE-1:0] rd_onehot_s;

  function automatic logic src_ready(input logic [CNT_W-1:0] c);
`ifdef CORE_DISPATCH_BYPASS_EN
    return (c <= CNT_W'(1));
`else
    return (c == {CNT_W{1'b0}});
`endif
  endfunction

  // Hazard checks against the scoreboard and the older issued slots.
  always_comb begin
    lat_s       = CNT_W'(lat_of(d.ctrl, ALU_LAT, MUL_LAT, LDST_LAT));
    raw_sb_s    = (!d.uses_ra || src_ready(cnt[d.ra])) &&
                  (!d.uses_rb || src_ready(cnt[d.rb]));
    // Younger write must not land before an older in-flight write to rd.
    waw_sb_s    = !d.data.writeback || (cnt[d.rd] <= lat_s);
    raw_ib_s    = !(d.uses_ra && sum_in.dest_mask[d.ra]) &&
                  !(d.uses_rb && sum_in.dest_mask[d.rb]);
    waw_ib_s    = !d.data.writeback || !sum_in.dest_mask[d.rd];
    struct_s    = !(d.ctrl.mul && sum_in.mul_used) && !(d.ctrl.ldst && sum_in.ldst_used);
    ok          = sum_in.prev_ok && !sum_in.branch_seen &&
                  (!d.ctrl.execute || (raw_sb_s && waw_sb_s && raw_ib_s && waw_ib_s && struct_s));
    commit_s    = ok && d.ctrl.execute;
    rd_onehot_s = {{(REG_SPACE-1){1'b0}}, 1'b1} << d.rd;

    sum_out.prev_ok     = ok;
    sum_out.dest_mask   = sum_in.dest_mask |
                          ((commit_s && d.data.writeback) ? rd_onehot_s : {REG_SPACE{1'b0}});
    sum_out.mul_used    = sum_in.mul_used    || (commit_s && d.ctrl.mul);
    sum_out.ldst_used   = sum_in.ldst_used   || (commit_s && d.ctrl.ldst);
    sum_out.branch_seen = sum_in.branch_seen || (commit_s && d.ctrl.branch);
  end

endmodule

// File: rtl/core_dispatch_scoreboard.sv
// In-order dispatch gate: issues the longest hazard-free prefix of the bundle and
// tracks in-flight writes with per-register countdowns. Optional: CORE_DISPATCH_BYPASS_EN.
module core_dispatch_scoreboard
  import core_dispatch_scoreboard_pkg::*;
#(
  parameter int ISSUE_W  = 2,
  parameter int NREGS    = 16,
  parameter int ALU_LAT  = DEF_ALU_LAT,
  parameter int MUL_LAT  = DEF_MUL_LAT,
  parameter int LDST_LAT = DEF_LDST_LAT
) (
  input  logic                       clk,
  input  logic                       rst_n,
  core_dispatch_scoreboard_if.slave  dif
);

  localparam int CNT_W  = cnt_width(ALU_LAT, MUL_LAT, LDST_LAT);
  localparam int CNT_CW = $clog2(ISSUE_W + 1);

  logic [NREGS-1:0][CNT_W-1:0] cnt_r;
  logic [NREGS-1:0][CNT_W-1:0] cnt_nxt_s;
  logic [NREGS-1:0]            busy_r;
  logic [NREGS-1:0]            busy_nxt_s;
  logic [ISSUE_W-1:0]          ok_s;
  logic [CNT_CW-1:0]           count_s;
  logic [CNT_W-1:0]            val_s;
  issue_summary_t              sum_s [ISSUE_W+1];

  // Reset also gates issue so the combinational outputs read zero during reset.
  assign sum_s[0] = '{
    prev_ok:     rst_n && dif.bundle_valid && !dif.flush && !dif.be_stall,
    dest_mask:   {REG_SPACE{1'b0}},
    mul_used:    1'b0,
    ldst_used:   1'b0,
    branch_seen: 1'b0
  };

  for (genvar k = 0; k < ISSUE_W; k++) begin : g_slot
    core_dispatch_slot_check #(
      .NREGS    (NREGS),
      .ALU_LAT  (ALU_LAT),
      .MUL_LAT  (MUL_LAT),
      .LDST_LAT (LDST_LAT),
      .CNT_W    (CNT_W)
    ) u_check (
      .d       (dif.dec[k]),
      .cnt     (cnt_r),
      .sum_in  (sum_s[k]),
      .ok      (ok_s[k]),
      .sum_out (sum_s[k+1])
    );
  end

  // Popcount of the issued prefix.
  always_comb begin
    count_s = {CNT_CW{1'b0}};
    for (int k = 0; k < ISSUE_W; k++) begin
      count_s = count_s + CNT_CW'(ok_s[k]);
    end
  end

  // Next counter state: hold on stall, else drain; new issues override the drain.
  always_comb begin
    cnt_nxt_s  = cnt_r;
    busy_nxt_s = busy_r;
    val_s      = {CNT_W{1'b0}};
    for (int r = 0; r < NREGS; r++) begin
      val_s = dif.be_stall ? cnt_r[r] :
              ((cnt_r[r] != {CNT_W{1'b0}}) ? (cnt_r[r] - CNT_W'(1)) : {CNT_W{1'b0}});
      for (int k = 0; k < ISSUE_W; k++) begin
        val_s = (ok_s[k] && dif.dec[k].ctrl.execute && dif.dec[k].data.writeback &&
                 (dif.dec[k].rd == REG_W'(r)))
                ? CNT_W'(lat_of(dif.dec[k].ctrl, ALU_LAT, MUL_LAT, LDST_LAT))
                : val_s;
      end
      cnt_nxt_s[r]  = val_s;
      busy_nxt_s[r] = (val_s != {CNT_W{1'b0}});
    end
  end

  // Counter array and registered busy map.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r  <= {(NREGS*CNT_W){1'b0}};
      busy_r <= {NREGS{1'b0}};
    end else begin
      cnt_r  <= cnt_nxt_s;
      busy_r <= busy_nxt_s;
    end
  end

  assign dif.issue_mask  = ok_s;
  assign dif.issue_count = count_s;
  assign dif.busy        = busy_r;

endmodule
